// File: rtl/if_fetch.sv
// if_fetch: PC and single-outstanding fetch to the icache, with an instruction queue
// presenting up to two sequential words per cycle to the IF/ID slot pair.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  D_pop,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        F_inst_ok1,
    output logic        F_inst_ok2,
    output logic [31:0] F_addr1,
    output logic [31:0] F_addr2,
    output logic [31:0] F_data1,
    output logic [31:0] F_data2,
    output logic        fetch_adel
);
    localparam int AW = $clog2(QDEPTH);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;
    state_e        state_q;
    logic [31:0]   pc_q, pc_d, req_pc_q;
    logic          halt_q, halt_d, adel_q;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [31:0]   addr_q [QDEPTH];
    logic [31:0]   data_q [QDEPTH];
    logic          enq, two, misal;
    logic [1:0]    pop, n_enq;

    assign misal      = redirect_pc[1:0] != 2'b00;
    // Free-space test uses the registered count so a same-cycle pop never causes overflow.
    assign inst_req   = state_q == S_REQ && !redirect && !halt_q
                        && count_q <= (AW+1)'(QDEPTH - 2);
    assign inst_addr  = {pc_q[31:3], 3'b000};
    assign enq        = state_q == S_WAIT && inst_data_ok && !redirect;
    assign two        = !req_pc_q[2];
    assign n_enq      = enq ? (two ? 2'd2 : 2'd1) : 2'd0;
    assign pop        = redirect ? 2'd0 : D_pop;
    assign head1      = head_q + AW'(1);
    assign tail1      = tail_q + AW'(1);
    assign F_inst_ok1 = !redirect && count_q != '0;
    assign F_inst_ok2 = !redirect && count_q >= (AW+1)'(2);
    assign F_addr1    = F_inst_ok1 ? addr_q[head_q] : '0;
    assign F_data1    = F_inst_ok1 ? data_q[head_q] : '0;
    assign F_addr2    = F_inst_ok2 ? addr_q[head1] : '0;
    assign F_data2    = F_inst_ok2 ? data_q[head1] : '0;
    assign fetch_adel = adel_q;

    always_comb begin
        pc_d    = enq ? {req_pc_q[31:3], 3'b000} + 32'd8 : pc_q;
        halt_d  = halt_q;
        count_d = count_q + (AW+1)'(n_enq) - (AW+1)'(pop);
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(n_enq);
        if (redirect) begin
            pc_d    = redirect_pc;
            halt_d  = misal;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            halt_q   <= 1'b0;
            adel_q   <= 1'b0;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            adel_q  <= redirect && misal;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            case (state_q)
                S_REQ: if (inst_req && inst_addr_ok) begin
                    state_q  <= S_WAIT;
                    req_pc_q <= pc_q;
                end
                S_WAIT: state_q <= inst_data_ok ? S_REQ : (redirect ? S_DROP : S_WAIT);
                S_DROP: if (inst_data_ok) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end
    end

    // A request at PC[2]=1 carries only the upper word of the 8-byte block.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= req_pc_q;
            data_q[tail_q] <= two ? inst_rdata[31:0] : inst_rdata[63:32];
            if (two) begin
                addr_q[tail1] <= req_pc_q + 32'd4;
                data_q[tail1] <= inst_rdata[63:32];
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: cache model plus scoreboard of expected queue entries for if_fetch.
module tb_if_fetch;
    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam int QD = 8;

    logic        clk = 0, resetn = 0, redirect = 0;
    logic [31:0] redirect_pc = 0;
    logic [1:0]  D_pop = 0;
    logic        inst_req, inst_addr_ok = 0, inst_data_ok = 0;
    logic [31:0] inst_addr;
    logic [63:0] inst_rdata = 0;
    logic        F_inst_ok1, F_inst_ok2, fetch_adel;
    logic [31:0] F_addr1, F_addr2, F_data1, F_data2;

    typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
    ent_t        q[$];
    logic [31:0] pop_log[$];
    int          checks = 0, failures = 0;
    logic        pend = 0, drop_m = 0, halt_m = 0, adel_m = 0, redir_r = 0;
    logic [31:0] pend_pc = 0, exp_pc = RPC, rpc_r = 0, last_req = 0;
    int          pend_wait = 0, lat = 1, pop_r = 0, nreq = 0;

    if_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .resetn(resetn), .redirect(redirect), .redirect_pc(redirect_pc),
        .D_pop(D_pop), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .F_inst_ok1(F_inst_ok1), .F_inst_ok2(F_inst_ok2), .F_addr1(F_addr1), .F_addr2(F_addr2),
        .F_data1(F_data1), .F_data2(F_data2), .fetch_adel(fetch_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'h2400_0000 + ((a - RPC) >> 2) + 32'd1;
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic tick();
        int n;
        logic exp_req, ok1, ok2;
        logic [31:0] base;
        n = pop_r > q.size() ? q.size() : pop_r;
        base = {pend_pc[31:3], 3'b000};
        redirect = redir_r;
        redirect_pc = rpc_r;
        D_pop = redir_r ? 2'd0 : 2'(n);
        inst_data_ok = pend && pend_wait == 0;
        inst_rdata = {w(base + 32'd4), w(base)};
        #1;
        inst_addr_ok = inst_req;
        #1;
        exp_req = !redir_r && !halt_m && !pend && q.size() <= QD - 2;
        ok1 = !redir_r && q.size() >= 1;
        ok2 = !redir_r && q.size() >= 2;
        checks++;
        if (inst_req !== exp_req) begin failures++; $display("FAIL inst_req got=%b exp=%b t=%0t", inst_req, exp_req, $time); end
        if (exp_req) begin
            checks++;
            if (inst_addr !== {exp_pc[31:3], 3'b000}) begin failures++; $display("FAIL inst_addr got=%h exp=%h", inst_addr, {exp_pc[31:3], 3'b000}); end
        end
        checks++;
        if (F_inst_ok1 !== ok1 || F_inst_ok2 !== ok2) begin failures++; $display("FAIL slot_ok got=%b%b exp=%b%b t=%0t", F_inst_ok1, F_inst_ok2, ok1, ok2, $time); end
        checks++;
        if (ok1 && (F_addr1 !== q[0].a || F_data1 !== q[0].d)) begin failures++; $display("FAIL slot1 got=%h/%h exp=%h/%h", F_addr1, F_data1, q[0].a, q[0].d); end
        else if (!ok1 && (F_addr1 !== 0 || F_data1 !== 0)) begin failures++; $display("FAIL slot1_zero got=%h/%h exp=0/0", F_addr1, F_data1); end
        checks++;
        if (ok2 && (F_addr2 !== q[1].a || F_data2 !== q[1].d)) begin failures++; $display("FAIL slot2 got=%h/%h exp=%h/%h", F_addr2, F_data2, q[1].a, q[1].d); end
        else if (!ok2 && (F_addr2 !== 0 || F_data2 !== 0)) begin failures++; $display("FAIL slot2_zero got=%h/%h exp=0/0", F_addr2, F_data2); end
        checks++;
        if (fetch_adel !== adel_m) begin failures++; $display("FAIL fetch_adel got=%b exp=%b", fetch_adel, adel_m); end
        adel_m = redir_r && rpc_r[1:0] != 2'b00;
        if (!redir_r) repeat (n) begin pop_log.push_back(q[0].a); void'(q.pop_front()); end
        if (inst_data_ok && !drop_m && !redir_r) begin
            if (!pend_pc[2]) begin
                push(pend_pc, w(base));
                push(pend_pc + 32'd4, w(base + 32'd4));
            end else push(pend_pc, w(base + 32'd4));
            exp_pc = base + 32'd8;
        end
        if (inst_data_ok) begin pend = 0; drop_m = 0; end
        else if (pend) pend_wait--;
        if (redir_r) begin
            q.delete();
            exp_pc = rpc_r;
            halt_m = rpc_r[1:0] != 2'b00;
            if (pend) drop_m = 1;
        end
        if (inst_addr_ok) begin
            pend = 1;
            pend_pc = exp_pc;
            pend_wait = lat - 1;
            last_req = inst_addr;
            nreq++;
        end
        redir_r = 0;
        @(posedge clk);
        #1;
        redirect = 0;
        D_pop = 0;
        inst_addr_ok = 0;
        inst_data_ok = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        redirect = 0; D_pop = 0; inst_addr_ok = 0; inst_data_ok = 0;
        redir_r = 0; pop_r = 0; lat = 1;
        q.delete(); pend = 0; drop_m = 0; halt_m = 0; adel_m = 0; exp_pc = RPC;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        #1;
    endtask

    task automatic wait_req(input string name);
        int n0;
        n0 = nreq;
        for (int i = 0; i < 50 && nreq == n0; i++) tick();
        checks++;
        if (nreq == n0) begin failures++; $display("FAIL %s_timeout got=no_request exp=request", name); end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && pend; i++) tick();
        checks++;
        if (pend) begin failures++; $display("FAIL %s_timeout got=pending exp=response", name); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (F_inst_ok1 !== 0 || F_inst_ok2 !== 0 || F_addr1 !== 0 || F_data2 !== 0 || fetch_adel !== 0) begin
            failures++; $display("FAIL reset_outputs got=%b%b %h %h %b exp=00 0 0 0", F_inst_ok1, F_inst_ok2, F_addr1, F_data2, fetch_adel);
        end
        release_reset();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RPC) begin failures++; $display("FAIL reset_req got=%b/%h exp=1/%h", inst_req, inst_addr, RPC); end
    endtask

    task automatic test_first_fetch();
        pop_r = 0;
        lat = 1;
        tick();
        tick();
        checks++;
        if (F_inst_ok1 !== 1 || F_inst_ok2 !== 1) begin failures++; $display("FAIL first_ok got=%b%b exp=11", F_inst_ok1, F_inst_ok2); end
        checks++;
        if (F_addr1 !== 32'hBFC0_0000 || F_data1 !== 32'h2400_0001) begin failures++; $display("FAIL first_slot1 got=%h/%h exp=bfc00000/24000001", F_addr1, F_data1); end
        checks++;
        if (F_addr2 !== 32'hBFC0_0004 || F_data2 !== 32'h2400_0002) begin failures++; $display("FAIL first_slot2 got=%h/%h exp=bfc00004/24000002", F_addr2, F_data2); end
    endtask

    task automatic test_full();
        pop_r = 0;
        for (int i = 0; i < 60 && (q.size() < QD || pend); i++) tick();
        tick();
        tick();
        checks++;
        if (inst_req !== 1'b0 || q.size() != QD) begin failures++; $display("FAIL full_stall got=%b/%0d exp=0/%0d", inst_req, q.size(), QD); end
        pop_r = 2;
        tick();
        pop_r = 0;
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0020) begin failures++; $display("FAIL full_resume got=%b/%h exp=1/bfc00020", inst_req, inst_addr); end
        pop_r = 2;
        repeat (20) tick();
    endtask

    task automatic test_redirect_wait();
        lat = 4;
        pop_r = 0;
        for (int i = 0; i < 50 && !(pend && pend_wait >= 2); i++) tick();
        redir_r = 1;
        rpc_r = 32'h8000_0104;
        tick();
        checks++;
        if (F_inst_ok1 !== 1'b0) begin failures++; $display("FAIL rw_flush got=%b exp=0", F_inst_ok1); end
        wait_req("rw_req");
        checks++;
        if (last_req !== 32'h8000_0100) begin failures++; $display("FAIL rw_addr got=%h exp=80000100", last_req); end
        wait_idle("rw_data");
        checks++;
        if (F_inst_ok1 !== 1 || F_inst_ok2 !== 0 || F_addr1 !== 32'h8000_0104 || F_data1 !== w(32'h8000_0104)) begin
            failures++; $display("FAIL rw_single got=%b%b %h/%h exp=10 80000104/%h", F_inst_ok1, F_inst_ok2, F_addr1, F_data1, w(32'h8000_0104));
        end
        wait_req("rw_next");
        checks++;
        if (last_req !== 32'h8000_0108) begin failures++; $display("FAIL rw_next_addr got=%h exp=80000108", last_req); end
    endtask

    task automatic test_redirect_data();
        lat = 2;
        pop_r = 2;
        for (int i = 0; i < 50 && !(pend && pend_wait == 0); i++) tick();
        redir_r = 1;
        rpc_r = 32'h8000_0300;
        tick();
        checks++;
        if (F_inst_ok1 !== 1'b0) begin failures++; $display("FAIL rd_flush got=%b exp=0", F_inst_ok1); end
        pop_r = 0;
        wait_req("rd_req");
        checks++;
        if (last_req !== 32'h8000_0300) begin failures++; $display("FAIL rd_addr got=%h exp=80000300", last_req); end
        wait_idle("rd_data");
        checks++;
        if (F_addr1 !== 32'h8000_0300 || F_addr2 !== 32'h8000_0304) begin failures++; $display("FAIL rd_entries got=%h/%h exp=80000300/80000304", F_addr1, F_addr2); end
    endtask

    task automatic test_adel();
        int n0;
        lat = 1;
        pop_r = 0;
        redir_r = 1;
        rpc_r = 32'h8000_0102;
        tick();
        checks++;
        if (fetch_adel !== 1'b1) begin failures++; $display("FAIL adel_pulse got=%b exp=1", fetch_adel); end
        tick();
        checks++;
        if (fetch_adel !== 1'b0) begin failures++; $display("FAIL adel_once got=%b exp=0", fetch_adel); end
        n0 = nreq;
        repeat (10) tick();
        checks++;
        if (nreq != n0 || inst_req !== 1'b0) begin failures++; $display("FAIL adel_halt got=%0d/%b exp=%0d/0", nreq, inst_req, n0); end
        redir_r = 1;
        rpc_r = 32'h8000_0200;
        tick();
        wait_req("adel_resume");
        checks++;
        if (last_req !== 32'h8000_0200) begin failures++; $display("FAIL adel_resume_addr got=%h exp=80000200", last_req); end
    endtask

    task automatic test_wrap();
        lat = 1;
        pop_log.delete();
        for (int i = 0; i < 60; i++) begin
            pop_r = (i % 3 == 0) ? 2 : 1;
            tick();
        end
        pop_r = 0;
        checks++;
        if (pop_log.size() < 20) begin failures++; $display("FAIL wrap_count got=%0d exp>=20", pop_log.size()); end
        for (int k = 1; k < pop_log.size(); k++) begin
            checks++;
            if (pop_log[k] !== pop_log[k-1] + 32'd4) begin failures++; $display("FAIL wrap_order got=%h exp=%h", pop_log[k], pop_log[k-1] + 32'd4); end
        end
    endtask

    task automatic test_mid_reset();
        lat = 3;
        pop_r = 0;
        for (int i = 0; i < 50 && !(pend && q.size() > 0); i++) tick();
        do_reset();
        checks++;
        if (F_inst_ok1 !== 0 || F_addr1 !== 0 || fetch_adel !== 0) begin failures++; $display("FAIL midreset_clear got=%b/%h/%b exp=0/0/0", F_inst_ok1, F_addr1, fetch_adel); end
        release_reset();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RPC) begin failures++; $display("FAIL midreset_req got=%b/%h exp=1/%h", inst_req, inst_addr, RPC); end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_full();
        test_redirect_wait();
        test_redirect_data();
        test_adel();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit at the head of the dual-issue pipeline. Holds the PC and issues 8-byte-aligned fetch requests to the instruction cache over a req/addr_ok/data_ok handshake. Buffers the returned instruction words in an 8-entry queue and presents up to two of them per cycle on the F_* slot pair consumed by the IF/ID stage. Handles redirects from branch/exception logic, including discarding an in-flight cache response.

## Interface
- RESET_PC, 32'hBFC0_0000: PC loaded on reset.
- QDEPTH, 8: queue depth in instructions (power of two, ≥4).
- clk  in  1  clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- D_pop  in  2  instructions consumed this cycle from the presented slots (0..2; must not exceed F_inst_ok1+F_inst_ok2).
- inst_req  out  1  cache request valid.
- inst_addr  out  32  request address, {pc[31:3],3'b000}.
- inst_addr_ok  in  1  cache accepted request.
- inst_data_ok  in  1  response valid.
- inst_rdata  in  64  [31:0] word at inst_addr, [63:32] word at inst_addr+4.
- F_inst_ok1 / F_inst_ok2  out  1 each  slot 1 / slot 2 valid.
- F_addr1 / F_addr2  out  32 each  slot PCs.
- F_data1 / F_data2  out  32 each  slot instruction words.
- fetch_adel  out  1  one-cycle pulse: misaligned redirect target.

## Operation
- Queue: circular buffer of {addr,data}, head/tail pointers wrap mod QDEPTH, count 0..QDEPTH. Slot 1 = head, slot 2 = head+1. F_inst_ok1 = count≥1, F_inst_ok2 = count≥2, both forced 0 in a redirect cycle. Invalid slots drive addr/data 0.
- FSM, at most one outstanding request:
  - S_REQ: inst_req = !redirect && (QDEPTH−count) ≥ 2 && !halt. On inst_addr_ok → S_WAIT, latch request PC.
  - S_WAIT: on inst_data_ok enqueue and → S_REQ. If request PC[2]==0 enqueue two entries (PC, rdata[31:0]), (PC+4, rdata[63:32]); else one entry (PC, rdata[63:32]). pc ← {PC[31:3],3'b000}+8 (wraps mod 2^32).
  - S_DROP: outstanding response to be discarded; on inst_data_ok → S_REQ, nothing enqueued.
- Redirect (top priority): queue emptied, D_pop ignored, pc ← redirect_pc. S_WAIT → S_DROP (S_WAIT with data_ok same cycle → S_REQ, data dropped); S_DROP stays S_DROP; S_REQ stays S_REQ.
- redirect_pc[1:0]≠0: fetch_adel pulses next cycle; halt set, no requests until next aligned redirect.
- Enqueue and D_pop in the same cycle both take effect; free-space check uses registered count (conservative, never overflows).

## Timing
- Reset values: pc=RESET_PC, S_REQ, count=0, halt=0; F_inst_ok1/2=0, F_addr*/F_data*=0, fetch_adel=0. inst_req=1 with inst_addr=32'hBFC0_0000 in the first cycle after resetn rises.
- inst_req/inst_addr held stable until inst_addr_ok. Cache returns data_ok ≥1 cycle after addr_ok.
- Latency: entries visible on F_* the cycle after inst_data_ok. Next request may assert the cycle after inst_data_ok.
- Redirect: F_* zero in the redirect cycle. New-target request no earlier than next cycle (S_REQ), or after the dropped response (S_DROP).
- Reset asserted mid-transaction clears all state immediately. Cache shares reset, so no stale response arrives.

## Test plan
- Reset release, cache addr_ok immediate, data_ok 1 cycle later with rdata=64'h2400_0002_2400_0001, D_pop=0 → req at BFC00000; next cycle F_inst_ok1/2=1, F_addr1=BFC00000, F_data1=24000001, F_addr2=BFC00004, F_data2=24000002.
- D_pop held 0 → after 4 responses count=8, inst_req stays 0. D_pop=2 for one cycle → inst_req reasserts with addr BFC00020.
- Redirect to 8000_0104 while in S_WAIT → queue empties, F_inst_ok*=0. The pending response is discarded. Next request addr 8000_0100, single entry (8000_0104, rdata[63:32]) enqueued; following request 8000_0108.
- Redirect coincident with inst_data_ok → data not enqueued, next request uses redirect target.
- Redirect to 8000_0102 → fetch_adel pulses once, inst_req 0 indefinitely. Redirect to 8000_0200 → fetch resumes.
- D_pop=1 alternating with 2-entry enqueues across pointer wrap at index 7→0 → F_addr order strictly sequential, no lost or duplicated entries.
